// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : control_unit
//  Purpose  : RV32I instruction decoder. Turns a 32-bit instruction word into
//             the datapath control bundle (ALU op, operand select, memory
//             read/write, branch/jump select, write-back source, register
//             write enable) plus the raw register-index fields. Every output
//             is registered, so the bundle appears one clock after the word.
//  Ports    : clk             rising-edge clock
//             rst             asynchronous active-high reset (outputs -> 0)
//             instructionWord instruction to decode
//             MemReg, MemWr   load / store strobes
//             Branch          control transfer (branch, JAL, JALR)
//             BranchSelect    00 seq, 01 cond branch, 10 JAL, 11 JALR
//             ALU_ctrl        ALU operation code
//             ALU_src         0 = rs2, 1 = immediate
//             RegD            one-hot write-back source
//             Regwr           register file write enable (0 when rd = x0)
//             rs1, rs2, rd    raw register fields
//  Options  : CU_STRICT_DECODE_EN - validate funct7/funct3 fields; encodings
//             outside the legal set decode as NOP.
//  Revision : 1.0 - initial release
// ============================================================================
module control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instructionWord,
   output logic        MemReg,
   output logic        MemWr,
   output logic        Branch,
   output logic [1:0]  BranchSelect,
   output logic [3:0]  ALU_ctrl,
   output logic        ALU_src,
   output logic [4:0]  RegD,
   output logic        Regwr,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd
);

   localparam logic [6:0] c_OP_R      = 7'b0110011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

   localparam logic [4:0] c_WB_NONE   = 5'b00000;
   localparam logic [4:0] c_WB_ALU    = 5'b00001;
   localparam logic [4:0] c_WB_MEM    = 5'b00010;
   localparam logic [4:0] c_WB_PC4    = 5'b00100;
   localparam logic [4:0] c_WB_UIMM   = 5'b01000;
   localparam logic [4:0] c_WB_PCUIMM = 5'b10000;

   localparam logic [3:0] c_ALU_ADD   = 4'b0000;

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_alt;

   assign w_opcode = instructionWord[6:0];
   assign w_funct3 = instructionWord[14:12];
   assign w_funct7 = instructionWord[31:25];
   assign w_alt    = instructionWord[30];

   // Field legality; all true unless strict decoding is compiled in.
   logic w_r_legal;
   logic w_imm_legal;
   logic w_jalr_legal;
   logic w_load_legal;
   logic w_store_legal;

`ifdef CU_STRICT_DECODE_EN
   // funct7 = 0100000 only means something for ADD/SUB and SRL/SRA.
   assign w_r_legal     = (w_funct7 == 7'b0000000) ||
                          ((w_funct7 == 7'b0100000) &&
                           ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)));
   // Only the shift-immediates carry funct7; other OP-IMM use it as imm bits.
   assign w_imm_legal   = (w_funct3 == 3'b001) ? (w_funct7 == 7'b0000000) :
                          (w_funct3 == 3'b101) ? ((w_funct7 == 7'b0000000) ||
                                                  (w_funct7 == 7'b0100000)) :
                          1'b1;
   assign w_jalr_legal  = (w_funct3 == 3'b000);
   assign w_load_legal  = !((w_funct3 == 3'b011) || (w_funct3 == 3'b110) ||
                            (w_funct3 == 3'b111));
   assign w_store_legal = (w_funct3 < 3'b011);
`else
   assign w_r_legal     = 1'b1;
   assign w_imm_legal   = 1'b1;
   assign w_jalr_legal  = 1'b1;
   assign w_load_legal  = 1'b1;
   assign w_store_legal = 1'b1;
`endif

   // Arithmetic/logic op from funct3; alt picks SUB over ADD and SRA over SRL.
   function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  arith_op = alt ? 4'b0001 : 4'b0000;
         3'b001:  arith_op = 4'b0010;
         3'b010:  arith_op = 4'b0011;
         3'b011:  arith_op = 4'b0100;
         3'b100:  arith_op = 4'b0101;
         3'b101:  arith_op = alt ? 4'b0111 : 4'b0110;
         3'b110:  arith_op = 4'b1000;
         default: arith_op = 4'b1001;
      endcase
   endfunction

   logic       mem_reg_d, mem_wr_d, branch_d, alu_src_d, regwr_d;
   logic [1:0] branch_sel_d;
   logic [3:0] alu_ctrl_d;
   logic [4:0] regd_d;

   always_comb begin
      mem_reg_d    = 1'b0;
      mem_wr_d     = 1'b0;
      branch_d     = 1'b0;
      branch_sel_d = 2'b00;
      alu_ctrl_d   = c_ALU_ADD;
      alu_src_d    = 1'b0;
      regd_d       = c_WB_NONE;
      regwr_d      = 1'b0;
      case (w_opcode)
         c_OP_R: if (w_r_legal) begin
            alu_ctrl_d = arith_op(w_funct3, w_alt);
            regd_d     = c_WB_ALU;
            regwr_d    = 1'b1;
         end
         c_OP_IMM: if (w_imm_legal) begin
            // bit30 is immediate data for ADDI; it only selects SRAI/SRLI.
            alu_ctrl_d = arith_op(w_funct3, (w_funct3 == 3'b101) && w_alt);
            alu_src_d  = 1'b1;
            regd_d     = c_WB_ALU;
            regwr_d    = 1'b1;
         end
         c_OP_LOAD: if (w_load_legal) begin
            alu_src_d = 1'b1;
            mem_reg_d = 1'b1;
            regd_d    = c_WB_MEM;
            regwr_d   = 1'b1;
         end
         c_OP_STORE: if (w_store_legal) begin
            alu_src_d = 1'b1;
            mem_wr_d  = 1'b1;
         end
         c_OP_BRANCH: if ((w_funct3 != 3'b010) && (w_funct3 != 3'b011)) begin
            branch_d     = 1'b1;
            branch_sel_d = 2'b01;
            // funct3 {000,001,100..111} maps onto 1010..1111 in order.
            alu_ctrl_d   = (w_funct3[2] == 1'b0) ? {3'b101, w_funct3[0]}
                                                 : {2'b11, w_funct3[1:0]};
         end
         c_OP_JAL: begin
            branch_d     = 1'b1;
            branch_sel_d = 2'b10;
            alu_src_d    = 1'b1;
            regd_d       = c_WB_PC4;
            regwr_d      = 1'b1;
         end
         c_OP_JALR: if (w_jalr_legal) begin
            branch_d     = 1'b1;
            branch_sel_d = 2'b11;
            alu_src_d    = 1'b1;
            regd_d       = c_WB_PC4;
            regwr_d      = 1'b1;
         end
         c_OP_LUI: begin
            regd_d  = c_WB_UIMM;
            regwr_d = 1'b1;
         end
         c_OP_AUIPC: begin
            regd_d  = c_WB_PCUIMM;
            regwr_d = 1'b1;
         end
         default: ;
      endcase
      // x0 is hard-wired zero: never write it, but leave RegD as decoded.
      if (instructionWord[11:7] == 5'd0) regwr_d = 1'b0;
   end

   logic       mem_reg_q, mem_wr_q, branch_q, alu_src_q, regwr_q;
   logic [1:0] branch_sel_q;
   logic [3:0] alu_ctrl_q;
   logic [4:0] regd_q, rs1_q, rs2_q, rd_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_reg_q    <= 1'b0;
         mem_wr_q     <= 1'b0;
         branch_q     <= 1'b0;
         branch_sel_q <= 2'b00;
         alu_ctrl_q   <= 4'b0000;
         alu_src_q    <= 1'b0;
         regd_q       <= 5'b00000;
         regwr_q      <= 1'b0;
         rs1_q        <= 5'd0;
         rs2_q        <= 5'd0;
         rd_q         <= 5'd0;
      end else begin
         mem_reg_q    <= mem_reg_d;
         mem_wr_q     <= mem_wr_d;
         branch_q     <= branch_d;
         branch_sel_q <= branch_sel_d;
         alu_ctrl_q   <= alu_ctrl_d;
         alu_src_q    <= alu_src_d;
         regd_q       <= regd_d;
         regwr_q      <= regwr_d;
         rs1_q        <= instructionWord[19:15];
         rs2_q        <= instructionWord[24:20];
         rd_q         <= instructionWord[11:7];
      end
   end

   assign MemReg       = mem_reg_q;
   assign MemWr        = mem_wr_q;
   assign Branch       = branch_q;
   assign BranchSelect = branch_sel_q;
   assign ALU_ctrl     = alu_ctrl_q;
   assign ALU_src      = alu_src_q;
   assign RegD         = regd_q;
   assign Regwr        = regwr_q;
   assign rs1          = rs1_q;
   assign rs2          = rs2_q;
   assign rd           = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_control_unit
//  Purpose  : Directed-vector bench for control_unit. The stimulus process
//             drives an instruction and queues its hand-computed control
//             bundle; an independent monitor pops and compares one cycle
//             later. Reset behaviour is checked directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

   logic        clk;
   logic        rst;
   logic [31:0] instructionWord;
   logic        MemReg, MemWr, Branch, ALU_src, Regwr;
   logic [1:0]  BranchSelect;
   logic [3:0]  ALU_ctrl;
   logic [4:0]  RegD, rs1, rs2, rd;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [30:0] bundle;
   } exp_t;

   exp_t exp_q[$];

   control_unit u_dut (
      .clk             (clk),
      .rst             (rst),
      .instructionWord (instructionWord),
      .MemReg          (MemReg),
      .MemWr           (MemWr),
      .Branch          (Branch),
      .BranchSelect    (BranchSelect),
      .ALU_ctrl        (ALU_ctrl),
      .ALU_src         (ALU_src),
      .RegD            (RegD),
      .Regwr           (Regwr),
      .rs1             (rs1),
      .rs2             (rs2),
      .rd              (rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Bundle order: MemReg MemWr Branch BranchSelect ALU_ctrl ALU_src RegD Regwr rs1 rs2 rd
   function automatic logic [30:0] pk(input logic mr, input logic mw, input logic br,
                                      input logic [1:0] bs, input logic [3:0] alu,
                                      input logic src, input logic [4:0] regd,
                                      input logic rw, input logic [4:0] r1,
                                      input logic [4:0] r2, input logic [4:0] d);
      pk = {mr, mw, br, bs, alu, src, regd, rw, r1, r2, d};
   endfunction

   function automatic logic [30:0] actual();
      actual = {MemReg, MemWr, Branch, BranchSelect, ALU_ctrl, ALU_src, RegD, Regwr,
                rs1, rs2, rd};
   endfunction

   task automatic check_now(input string name, input logic [30:0] exp_v);
      logic [30:0] act;
      act = actual();
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp_v);
      end
   endtask

   // Drive at the falling edge; the word is captured on the next rising edge.
   task automatic issue(input string name, input logic [31:0] iw, input logic [30:0] exp_v);
      exp_t e;
      @(negedge clk);
      instructionWord = iw;
      e.name   = name;
      e.bundle = exp_v;
      exp_q.push_back(e);
   endtask

   // Monitor: each output update (one per rising edge out of reset) is checked
   // against the oldest outstanding expectation.
   always @(posedge clk) begin
      #1;
      if (!rst && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_now(e.name, e.bundle);
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      #2;
      if (exp_q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      rst             = 1'b1;
      instructionWord = 32'h0000_00B3;
      #1;
      check_now("reset_before_clk", 31'd0);

      @(negedge clk);
      @(negedge clk);
      check_now("reset_held", 31'd0);
      rst = 1'b0;

      //                                      mr mw br bs     alu      src regd      rw r1 r2 d
      issue("add_x1",   32'h0000_00B3, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b00001, 1, 0, 0, 1));
      issue("sub",      32'h4020_8133, pk(0, 0, 0, 2'b00, 4'b0001, 0, 5'b00001, 1, 1, 2, 2));
      issue("lw",       32'h0000_A183, pk(1, 0, 0, 2'b00, 4'b0000, 1, 5'b00010, 1, 1, 0, 3));
      issue("beq",      32'h0020_8463, pk(0, 0, 1, 2'b01, 4'b1010, 0, 5'b00000, 0, 1, 2, 8));
      issue("jal",      32'h0080_00EF, pk(0, 0, 1, 2'b10, 4'b0000, 1, 5'b00100, 1, 0, 8, 1));
      issue("add_x0",   32'h0000_0033, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b00001, 0, 0, 0, 0));
      issue("illegal",  32'h0000_007F, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b00000, 0, 0, 0, 0));
      issue("srai",     32'h4010_D093, pk(0, 0, 0, 2'b00, 4'b0111, 1, 5'b00001, 1, 1, 1, 1));
      issue("addi_b30", 32'h4000_0093, pk(0, 0, 0, 2'b00, 4'b0000, 1, 5'b00001, 1, 0, 0, 1));
      issue("sw",       32'h0020_A223, pk(0, 1, 0, 2'b00, 4'b0000, 1, 5'b00000, 0, 1, 2, 4));
      issue("jalr",     32'h0000_80E7, pk(0, 0, 1, 2'b11, 4'b0000, 1, 5'b00100, 1, 1, 0, 1));
      issue("lui",      32'h1234_50B7, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b01000, 1, 8, 3, 1));
      issue("auipc",    32'h0000_0117, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b10000, 1, 0, 0, 2));
      issue("br_f3_2",  32'h0000_2063, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b00000, 0, 0, 0, 0));
      issue("bltu",     32'h0020_E463, pk(0, 0, 1, 2'b01, 4'b1110, 0, 5'b00000, 0, 1, 2, 8));
`ifdef CU_STRICT_DECODE_EN
      issue("r_f7_01",  32'h0200_00B3, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b00000, 0, 0, 0, 1));
      issue("jalr_f3",  32'h0000_90E7, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b00000, 0, 1, 0, 1));
`else
      issue("r_f7_01",  32'h0200_00B3, pk(0, 0, 0, 2'b00, 4'b0000, 0, 5'b00001, 1, 0, 0, 1));
      issue("jalr_f3",  32'h0000_90E7, pk(0, 0, 1, 2'b11, 4'b0000, 1, 5'b00100, 1, 1, 0, 1));
`endif
      drain();

      // Mid-stream reset: outputs hold a JALR bundle; a new word is in flight.
      @(negedge clk);
      instructionWord = 32'h0000_00B3;
      #2;
      rst = 1'b1;
      #1;
      check_now("async_reset", 31'd0);
      @(posedge clk);
      #1;
      check_now("reset_discards", 31'd0);
      @(negedge clk);
      rst = 1'b0;

      issue("after_rst", 32'h0020_8463, pk(0, 0, 1, 2'b01, 4'b1010, 0, 5'b00000, 0, 1, 2, 8));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
